// File: rtl/gray_step_decoder_pkg.sv
// Shared definitions for the Gray step decoder: FSM encodings, the four
// Gray codes of the {A,B} cycle and forward/reverse neighbour lookups.
package gray_step_decoder_pkg;

  // FSM encodings
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Gray codes {A,B} in forward order G0 -> G1 -> G2 -> G3 -> G0
  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b10;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b01;

  // Code that follows g when stepping forward
  function automatic logic [1:0] gray_next(input logic [1:0] g);
    logic [1:0] r;
    case (g)
      G0:      r = G1;
      G1:      r = G2;
      G2:      r = G3;
      G3:      r = G0;
      default: r = G0;
    endcase
    return r;
  endfunction

  // Code that follows g when stepping in reverse
  function automatic logic [1:0] gray_prev(input logic [1:0] g);
    logic [1:0] r;
    case (g)
      G0:      r = G3;
      G1:      r = G0;
      G2:      r = G1;
      G3:      r = G2;
      default: r = G0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gray_step_decoder_bit_sync.sv
// Single-bit input sampling chain of STAGES flops with synchronous
// active-low reset. Output is the last stage.
module gray_step_decoder_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the sampled bit down the chain each clock
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/gray_step_decoder.sv
// Receive-side decoder for a 2-bit Gray {A,B} pair: samples the inputs,
// decodes forward/reverse steps and illegal double-bit jumps, and keeps a
// wrapping position count. All outputs are registered.
module gray_step_decoder
  import gray_step_decoder_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [CNT_W-1:0] position,
  output logic             step_fwd,
  output logic             step_rev,
  output logic             dir,
  output logic             err,
  output logic             err_sticky
);

  // INIT lasts SYNC_STAGES+1 edges: fill the sync chain, then load prev.
  localparam logic [1:0]       INIT_LAST = 2'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] POS_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             a_sync_s, b_sync_s;
  logic [1:0]       cur_s;
  logic [0:0]       state_q, state_d;
  logic [1:0]       init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             fwd_q, fwd_d;
  logic             rev_q, rev_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  gray_step_decoder_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk_i   (Clk),
    .rst_n_i (rst),
    .d_i     (a_in),
    .q_o     (a_sync_s)
  );

  gray_step_decoder_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk_i   (Clk),
    .rst_n_i (rst),
    .d_i     (b_in),
    .q_o     (b_sync_s)
  );

  assign cur_s = {a_sync_s, b_sync_s};

  // Next-state: FSM sequencing, step decode, counter and clear handling
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = cur_s;
    pos_d      = pos_q;
    fwd_d      = 1'b0;
    rev_d      = 1'b0;
    dir_d      = dir_q;
    err_d      = 1'b0;
    sticky_d   = sticky_q;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        if (cur_s == gray_next(prev_q)) begin
          pos_d = pos_q + POS_ONE;
          fwd_d = 1'b1;
          dir_d = 1'b1;
        end else if (cur_s == gray_prev(prev_q)) begin
          pos_d = pos_q - POS_ONE;
          rev_d = 1'b1;
          dir_d = 1'b0;
        end else if (cur_s != prev_q) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
        end else begin
          pos_d = pos_q;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = 2'd0;
      end
    endcase

    // Clear wins over a simultaneous count or error, pulses still fire
    if (clr) begin
      pos_d    = '0;
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_d;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= 2'd0;
      prev_q     <= 2'b00;
      pos_q      <= '0;
      fwd_q      <= 1'b0;
      rev_q      <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      pos_q      <= pos_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
    end
  end

  assign position   = pos_q;
  assign step_fwd   = fwd_q;
  assign step_rev   = rev_q;
  assign dir        = dir_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_step_decoder.sv
// Self-checking bench for gray_step_decoder. The reference model keeps a
// history of applied {A,B} levels, treats each code as a position on a
// 4-step ring and classifies the ring distance between delayed samples.
module tb_gray_step_decoder;

  localparam int CNT_W = 8;
  localparam int S     = 2;

  logic             Clk = 1'b0;
  logic             rst = 1'b0;
  logic             a_in = 1'b0;
  logic             b_in = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] position;
  logic             step_fwd, step_rev, dir, err, err_sticky;

  gray_step_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .a_in       (a_in),
    .b_in       (b_in),
    .clr        (clr),
    .position   (position),
    .step_fwd   (step_fwd),
    .step_rev   (step_rev),
    .dir        (dir),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int passes = 0;

  // reference model state
  int         exp_pos = 0;
  logic       exp_fwd = 1'b0, exp_rev = 1'b0, exp_dir = 1'b0;
  logic       exp_err = 1'b0, exp_sticky = 1'b0;
  int         n_edges = 0;
  logic [1:0] hist[$];

  logic [CNT_W+4:0] obs_v, exp_v;
  assign obs_v = {position, step_fwd, step_rev, dir, err, err_sticky};
  always_comb begin
    exp_v = {exp_pos[CNT_W-1:0], exp_fwd, exp_rev, exp_dir, exp_err, exp_sticky};
  end

  // ring index of a Gray code along the forward order 00,10,11,01
  function automatic int gidx(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // drive one cycle of inputs, advance the model, settle past the edge
  task automatic step(input logic [1:0] ab, input logic c, input logic r);
    int d;
    a_in = ab[1];
    b_in = ab[0];
    clr  = c;
    rst  = r;
    @(posedge Clk);
    exp_fwd = 1'b0;
    exp_rev = 1'b0;
    exp_err = 1'b0;
    if (!r) begin
      exp_pos = 0; exp_dir = 1'b0; exp_sticky = 1'b0;
      n_edges = 0;
      hist.delete();
    end else begin
      n_edges++;
      hist.push_back(ab);
      if (hist.size() > S + 2) void'(hist.pop_front());
      // sample taken S edges ago versus the one before it
      if (n_edges >= S + 2) begin
        d = (gidx(hist[1]) - gidx(hist[0]) + 4) % 4;
        if (d == 1) begin
          exp_pos = (exp_pos + 1) % (1 << CNT_W);
          exp_fwd = 1'b1; exp_dir = 1'b1;
        end else if (d == 3) begin
          exp_pos = (exp_pos + (1 << CNT_W) - 1) % (1 << CNT_W);
          exp_rev = 1'b1; exp_dir = 1'b0;
        end else if (d == 2) begin
          exp_err = 1'b1; exp_sticky = 1'b1;
        end
      end
      if (c) begin
        exp_pos = 0; exp_sticky = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(2'b00, 1'b0, 1'b0);
      checks++;
      if (obs_v !== 13'd0) $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs_v, 13'd0);
      else passes++;
    end
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 1'b0, 1'b1);
      checks++;
      if (obs_v !== exp_v) $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, obs_v, exp_v);
      else passes++;
    end
    checks++;
    if (position !== 8'd0 || err_sticky !== 1'b0)
      $display("FAIL reset_final got pos=%h sticky=%b exp pos=00 sticky=0", position, err_sticky);
    else passes++;
  endtask

  task automatic test_forward();
    logic [1:0] seq[5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    int pulses = 0;
    for (int k = 1; k < 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(seq[k], 1'b0, 1'b1);
        if (step_fwd === 1'b1) pulses++;
        checks++;
        if (obs_v !== exp_v) $display("FAIL forward k%0d j%0d got=%h exp=%h", k, j, obs_v, exp_v);
        else passes++;
      end
    end
    for (int j = 0; j < 3; j++) begin
      step(2'b00, 1'b0, 1'b1);
      if (step_fwd === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 4 || position !== 8'd4 || dir !== 1'b1)
      $display("FAIL forward_total got pulses=%0d pos=%h dir=%b exp 4 04 1", pulses, position, dir);
    else passes++;
  endtask

  task automatic test_reverse_wrap();
    step(2'b00, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) step(2'b01, 1'b0, 1'b1);
    checks++;
    if (position !== 8'hFF || dir !== 1'b0 || obs_v !== exp_v)
      $display("FAIL reverse_wrap got pos=%h dir=%b exp pos=ff dir=0", position, dir);
    else passes++;
    for (int j = 0; j < 4; j++) step(2'b00, 1'b0, 1'b1);
    checks++;
    if (position !== 8'h00 || obs_v !== exp_v)
      $display("FAIL reverse_back got pos=%h exp pos=00", position);
    else passes++;
  endtask

  task automatic test_error();
    int errs = 0;
    for (int j = 0; j < 5; j++) begin
      step(2'b11, 1'b0, 1'b1);
      if (err === 1'b1) errs++;
      checks++;
      if (obs_v !== exp_v) $display("FAIL error j%0d got=%h exp=%h", j, obs_v, exp_v);
      else passes++;
    end
    checks++;
    if (errs !== 1 || err_sticky !== 1'b1 || position !== 8'h00)
      $display("FAIL error_pulse got errs=%0d sticky=%b pos=%h exp 1 1 00", errs, err_sticky, position);
    else passes++;
    step(2'b11, 1'b1, 1'b1);
    checks++;
    if (err_sticky !== 1'b0 || obs_v !== exp_v)
      $display("FAIL error_clr got sticky=%b exp sticky=0", err_sticky);
    else passes++;
  endtask

  task automatic test_clr_step();
    for (int j = 0; j < 3; j++) step(2'b01, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) step(2'b00, 1'b0, 1'b1);
    checks++;
    if (position !== 8'd2) $display("FAIL clr_pre got pos=%h exp pos=02", position);
    else passes++;
    for (int j = 0; j < S; j++) step(2'b10, 1'b0, 1'b1);
    step(2'b10, 1'b1, 1'b1);
    checks++;
    if (position !== 8'd0 || step_fwd !== 1'b1 || obs_v !== exp_v)
      $display("FAIL clr_step got pos=%h fwd=%b exp pos=00 fwd=1", position, step_fwd);
    else passes++;
  endtask

  task automatic test_reset_midrun();
    logic [1:0] seq[5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    foreach (seq[k]) for (int j = 0; j < 2; j++) step(seq[k], 1'b0, 1'b1);
    for (int j = 0; j < S; j++) step(2'b11, 1'b0, 1'b1);
    checks++;
    if (position !== 8'd5) $display("FAIL midrun_pre got pos=%h exp pos=05", position);
    else passes++;
    step(2'b11, 1'b0, 1'b0);
    checks++;
    if (obs_v !== 13'd0) $display("FAIL midrun_rst got=%h exp=%h", obs_v, 13'd0);
    else passes++;
    for (int j = 0; j < 8; j++) begin
      step(2'b11, 1'b0, 1'b1);
      checks++;
      if (obs_v !== 13'd0) $display("FAIL midrun_release j%0d got=%h exp=%h", j, obs_v, 13'd0);
      else passes++;
    end
    for (int j = 0; j < 4; j++) step(2'b01, 1'b0, 1'b1);
    checks++;
    if (position !== 8'd1 || dir !== 1'b1 || obs_v !== exp_v)
      $display("FAIL midrun_step got pos=%h dir=%b exp pos=01 dir=1", position, dir);
    else passes++;
  endtask

  task automatic test_random();
    logic [1:0] code = 2'b01;
    logic       c, r;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) code = 2'($urandom_range(0, 3));
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 99) != 0);
      step(code, c, r);
      checks++;
      if (obs_v !== exp_v) $display("FAIL random cyc%0d got=%h exp=%h", i, obs_v, exp_v);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_error();
    test_clr_step();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
